// File: rtl/core_pkg.sv
// core_pkg: opcode and sequencer state types plus instruction field positions
package core_pkg;
  typedef enum logic [2:0] {OP_LW, OP_SW, OP_BNEZ, OP_XOR, OP_INC, OP_SHL, OP_SHR, OP_AND} opcode_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE} seq_state_t;
  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int RD_HI = 5;
  localparam int RD_LO = 3;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;
endpackage

// File: rtl/core_ctrl_decoder.sv
// core_ctrl_decoder: classifies an opcode into memory, jump and two-register groups
module core_ctrl_decoder
  import core_pkg::*;
(
  input  logic [2:0] op,
  output logic       is_mem,
  output logic       is_jump,
  output logic       is_two_reg
);
  assign is_mem = op == OP_LW || op == OP_SW;
  assign is_jump = op == OP_BNEZ;
  assign is_two_reg = op == OP_XOR || op == OP_AND;
endmodule

// File: rtl/seq_mem_timer.sv
// seq_mem_timer: down-counter reloaded outside MEM, flags the last allowed wait cycle
module seq_mem_timer #(
  parameter int CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= load ? W'(CYCLES - 1) : count != '0 ? count - W'(1) : count;
  assign expired = count == '0;
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control for the 8-opcode core
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int INSTR_W = 9,
  parameter int PROG_LEN = 256,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               zero_flag,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic [INSTR_W-1:0] ir,
  output logic [2:0]         alu_op,
  output logic               two_reg,
  output logic               reg_we,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done,
  output logic               mem_err,
  output logic [15:0]        instr_count
);
  localparam logic [PC_W:0] END_PC = (PC_W + 1)'(PROG_LEN);
  seq_state_t state, nxt;
  logic [PC_W-1:0] pc_nxt, pc_inc, br_off;
  logic [2:0] op;
  logic is_mem, is_jump, is_two_reg, expired, retire, timeout, launch, pc_end;
  assign op = ir[OP_HI:OP_LO];
  assign imem_addr = pc;
  assign pc_inc = pc + PC_W'(1);
  assign pc_end = {1'b0, pc} + (PC_W + 1)'(1) == END_PC;
  assign br_off = {{(PC_W - 3){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
  assign launch = (state == S_IDLE || state == S_DONE) && start;
  core_ctrl_decoder u_dec (
    .op        (op),
    .is_mem    (is_mem),
    .is_jump   (is_jump),
    .is_two_reg(is_two_reg)
  );
  seq_mem_timer #(.CYCLES(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state != S_MEM),
    .expired(expired)
  );
  always_comb begin
    nxt = state;
    pc_nxt = pc;
    retire = 1'b0;
    timeout = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        nxt = launch ? S_FETCH : state;
        pc_nxt = launch ? '0 : pc;
      end
      S_FETCH: nxt = S_DECODE;
      S_DECODE: nxt = S_EXEC;
      S_EXEC:
        if (is_mem) nxt = S_MEM;
        else if (is_jump) begin
          retire = 1'b1;
          pc_nxt = zero_flag ? pc_inc : pc + br_off;
          nxt = zero_flag ? (pc_end ? S_DONE : S_FETCH) : (br_off == '0 ? S_DONE : S_FETCH);
        end else nxt = S_WB;
      S_MEM:
        if (dmem_ack && op == OP_SW) begin
          retire = 1'b1;
          pc_nxt = pc_inc;
          nxt = pc_end ? S_DONE : S_FETCH;
        end else if (dmem_ack) nxt = S_WB;
        else if (expired) begin
          timeout = 1'b1;
          nxt = S_DONE;
        end
      S_WB: begin
        retire = 1'b1;
        pc_nxt = pc_inc;
        nxt = pc_end ? S_DONE : S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      pc <= '0;
      ir <= '0;
      instr_count <= '0;
      mem_err <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      alu_op <= '0;
      two_reg <= 1'b0;
      reg_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      pc <= pc_nxt;
      ir <= state == S_FETCH ? imem_rdata : ir;
      instr_count <= launch ? '0 : (retire && instr_count != 16'hFFFF) ? instr_count + 16'd1 : instr_count;
      mem_err <= launch ? 1'b0 : mem_err | timeout;
      dmem_req <= nxt == S_MEM;
      dmem_we <= nxt == S_MEM && op == OP_SW;
      alu_op <= nxt == S_EXEC ? op : 3'b000;
      two_reg <= nxt == S_EXEC && is_two_reg;
      reg_we <= nxt == S_WB;
      busy <= nxt != S_IDLE && nxt != S_DONE;
      done <= nxt == S_DONE;
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: scoreboard-driven scenario checks of multicycle_sequencer
module tb_multicycle_sequencer;
  localparam int PC_W = 8;
  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT = 9'b010_000_000;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, zero_flag = 1'b0, dmem_ack = 1'b0;
  logic [PC_W-1:0] imem_addr, pc;
  logic [INSTR_W-1:0] imem_rdata, ir;
  logic dmem_req, dmem_we, two_reg, reg_we, busy, done, mem_err;
  logic [2:0] alu_op;
  logic [15:0] instr_count;
  logic [INSTR_W-1:0] imem [0:255];
  int n_cmp = 0, n_err = 0;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  always #5 clk = ~clk;
  assign imem_rdata = imem[imem_addr];
  multicycle_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .PROG_LEN(4), .MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .zero_flag  (zero_flag),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .ir         (ir),
    .alu_op     (alu_op),
    .two_reg    (two_reg),
    .reg_we     (reg_we),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .mem_err    (mem_err),
    .instr_count(instr_count)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT;
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    start = 1'b0;
    dmem_ack = 1'b0;
    zero_flag = 1'b0;
    #3;
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask
  task automatic test_reset();
    reset_dut();
    n_cmp++;
    if (pc !== 8'd0 || ir !== 9'd0 || instr_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_regs: pc=%0d ir=%0h cnt=%0d, expected 0/0/0", pc, ir, instr_count);
    end
    n_cmp++;
    if ({busy, done, mem_err, dmem_req, dmem_we, reg_we, two_reg} !== 7'b0 || alu_op !== 3'd0) begin
      n_err++;
      $display("FAIL reset_flags: busy=%b done=%b err=%b req=%b we=%b reg_we=%b two=%b alu=%0d, expected all 0",
               busy, done, mem_err, dmem_req, dmem_we, reg_we, two_reg, alu_op);
    end
  endtask
  task automatic test_reset_mid_mem();
    clear_imem();
    imem[0] = 9'b100_001_011;
    imem[1] = 9'b000_010_001;
    reset_dut();
    exp_q.push_back('{pc: 8'd1, cnt: 16'd1});
    pulse_start();
    for (int c = 0; c < 20 && !dmem_req; c++) cyc();
    e = exp_q.pop_front();
    n_cmp++;
    if (dmem_req !== 1'b1 || pc !== e.pc || instr_count !== e.cnt) begin
      n_err++;
      $display("FAIL mid_mem_entry: req=%b pc=%0d cnt=%0d, expected 1/%0d/%0d", dmem_req, pc, instr_count, e.pc, e.cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL mid_mem_async_req: req=%b, expected 0", dmem_req);
    end
    n_cmp++;
    if (pc !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || instr_count !== 16'd0) begin
      n_err++;
      $display("FAIL mid_mem_async_state: pc=%0d busy=%b done=%b cnt=%0d, expected 0/0/0/0", pc, busy, done, instr_count);
    end
    #1 rst_n = 1'b1;
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || dmem_req !== 1'b0 || pc !== 8'd0) begin
      n_err++;
      $display("FAIL mid_mem_idle: busy=%b req=%b pc=%0d, expected 0/0/0", busy, dmem_req, pc);
    end
  endtask
  task automatic test_alu();
    int we_at, we_n;
    clear_imem();
    imem[0] = 9'b100_001_011;
    reset_dut();
    exp_q.push_back('{pc: 8'd1, cnt: 16'd1});
    pulse_start();
    we_at = 0;
    we_n = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        n_cmp++;
        if (ir !== 9'b100_001_011) begin
          n_err++;
          $display("FAIL alu_ir: ir=%b, expected 100001011", ir);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (alu_op !== 3'b100 || two_reg !== 1'b0) begin
          n_err++;
          $display("FAIL alu_exec: alu_op=%b two_reg=%b, expected 100/0", alu_op, two_reg);
        end
      end
      if (reg_we) begin
        we_n++;
        if (we_at == 0) we_at = c;
      end
      if (c < 5) cyc();
    end
    n_cmp++;
    if (we_at != 4 || we_n != 1) begin
      n_err++;
      $display("FAIL alu_reg_we: first at cycle %0d, %0d cycles high, expected cycle 4 for 1 cycle", we_at, we_n);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (pc !== e.pc || instr_count !== e.cnt) begin
      n_err++;
      $display("FAIL alu_retire: pc=%0d cnt=%0d, expected %0d/%0d", pc, instr_count, e.pc, e.cnt);
    end
  endtask
  task automatic test_load();
    int req_at, req_n, we_at, we_bad;
    clear_imem();
    imem[0] = 9'b000_010_001;
    reset_dut();
    exp_q.push_back('{pc: 8'd1, cnt: 16'd1});
    pulse_start();
    req_at = 0;
    req_n = 0;
    we_at = 0;
    we_bad = 0;
    for (int c = 1; c <= 8; c++) begin
      if (dmem_req) begin
        req_n++;
        if (req_at == 0) req_at = c;
        if (dmem_we !== 1'b0) we_bad++;
      end
      if (reg_we && we_at == 0) we_at = c;
      dmem_ack = dmem_req && c == req_at + 2;
      if (c < 8) cyc();
    end
    dmem_ack = 1'b0;
    n_cmp++;
    if (req_at != 4 || req_n != 3) begin
      n_err++;
      $display("FAIL load_req: rose at cycle %0d, held %0d cycles, expected 4/3", req_at, req_n);
    end
    n_cmp++;
    if (we_bad != 0) begin
      n_err++;
      $display("FAIL load_we: dmem_we high in %0d request cycles, expected 0", we_bad);
    end
    n_cmp++;
    if (we_at != 7) begin
      n_err++;
      $display("FAIL load_wb: reg_we at cycle %0d, expected 7", we_at);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (pc !== e.pc || instr_count !== e.cnt || dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL load_retire: pc=%0d cnt=%0d req=%b, expected %0d/%0d/0", pc, instr_count, dmem_req, e.pc, e.cnt);
    end
  endtask
  task automatic test_branch();
    logic [PC_W-1:0] ep;
    for (int s = 0; s < 3; s++) begin
      clear_imem();
      imem[0] = 9'b010_000_011;
      imem[3] = 9'b010_000_010;
      imem[5] = s == 2 ? 9'b010_000_000 : 9'b010_001_110;
      ep = s == 0 ? 8'd3 : s == 1 ? 8'd6 : 8'd5;
      reset_dut();
      exp_q.push_back('{pc: ep, cnt: 16'd3});
      pulse_start();
      repeat (6) cyc();
      n_cmp++;
      if (pc !== 8'd5 || instr_count !== 16'd2) begin
        n_err++;
        $display("FAIL branch%0d_reach5: pc=%0d cnt=%0d, expected 5/2", s, pc, instr_count);
      end
      zero_flag = s == 1;
      repeat (3) cyc();
      e = exp_q.pop_front();
      n_cmp++;
      if (pc !== e.pc || instr_count !== e.cnt) begin
        n_err++;
        $display("FAIL branch%0d_target: pc=%0d cnt=%0d, expected %0d/%0d", s, pc, instr_count, e.pc, e.cnt);
      end
      n_cmp++;
      if (done !== (s == 2) || busy !== (s != 2)) begin
        n_err++;
        $display("FAIL branch%0d_halt: done=%b busy=%b, expected %b/%b", s, done, busy, s == 2, s != 2);
      end
    end
  endtask
  task automatic test_timeout();
    int req_n, we_bad, err_early;
    logic acked;
    clear_imem();
    imem[0] = 9'b001_000_000;
    reset_dut();
    exp_q.push_back('{pc: 8'd0, cnt: 16'd0});
    pulse_start();
    req_n = 0;
    we_bad = 0;
    err_early = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (dmem_req) begin
        req_n++;
        if (dmem_we !== 1'b1) we_bad++;
        if (mem_err) err_early++;
      end
      cyc();
    end
    n_cmp++;
    if (done !== 1'b1 || mem_err !== 1'b1 || dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_flag: done=%b err=%b req=%b, expected 1/1/0", done, mem_err, dmem_req);
    end
    n_cmp++;
    if (req_n != 15 || we_bad != 0 || err_early != 0) begin
      n_err++;
      $display("FAIL timeout_wait: %0d MEM cycles, we low %0d, early err %0d, expected 15/0/0", req_n, we_bad, err_early);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (pc !== e.pc || instr_count !== e.cnt) begin
      n_err++;
      $display("FAIL timeout_noretire: pc=%0d cnt=%0d, expected %0d/%0d", pc, instr_count, e.pc, e.cnt);
    end
    exp_q.push_back('{pc: 8'd1, cnt: 16'd1});
    pulse_start();
    n_cmp++;
    if (mem_err !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear: err=%b busy=%b done=%b, expected 0/1/0", mem_err, busy, done);
    end
    req_n = 0;
    acked = 1'b0;
    for (int c = 0; c < 40 && !acked; c++) begin
      if (dmem_req) req_n++;
      dmem_ack = dmem_req && req_n == 15;
      acked = dmem_ack;
      cyc();
    end
    dmem_ack = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (acked !== 1'b1 || mem_err !== 1'b0 || pc !== e.pc || instr_count !== e.cnt || done !== 1'b0) begin
      n_err++;
      $display("FAIL ack_on_last: acked=%b err=%b pc=%0d cnt=%0d done=%b, expected 1/0/%0d/%0d/0",
               acked, mem_err, pc, instr_count, done, e.pc, e.cnt);
    end
  endtask
  task automatic test_end_of_program();
    logic [3:0] tr;
    int we_n;
    clear_imem();
    imem[0] = 9'b011_001_010;
    imem[1] = 9'b100_010_000;
    imem[2] = 9'b101_011_000;
    imem[3] = 9'b111_100_101;
    reset_dut();
    exp_q.push_back('{pc: 8'd4, cnt: 16'd4});
    dmem_ack = 1'b1;
    pulse_start();
    tr = '0;
    we_n = 0;
    for (int c = 1; c <= 17; c++) begin
      start = c == 2;
      if (c == 16) begin
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL eop_early: done=%b busy=%b at cycle 16, expected 0/1", done, busy);
        end
      end
      if (c % 4 == 3) tr = {tr[2:0], two_reg};
      if (reg_we) we_n++;
      if (c < 17) cyc();
    end
    start = 1'b0;
    dmem_ack = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL eop_done: done=%b busy=%b req=%b, expected 1/0/0", done, busy, dmem_req);
    end
    n_cmp++;
    if (tr !== 4'b1001 || we_n != 4) begin
      n_err++;
      $display("FAIL eop_exec: two_reg pattern=%b writes=%0d, expected 1001/4", tr, we_n);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (pc !== e.pc || instr_count !== e.cnt) begin
      n_err++;
      $display("FAIL eop_retire: pc=%0d cnt=%0d, expected %0d/%0d", pc, instr_count, e.pc, e.cnt);
    end
  endtask
  initial begin
    clear_imem();
    test_reset();
    test_reset_mid_mem();
    test_alu();
    test_load();
    test_branch();
    test_timeout();
    test_end_of_program();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FETCH/DECODE/EXEC/MEM/WB state machine that drives the 8-opcode core datapath.
- Owns the PC, the instruction register, the data-memory request handshake and the register-file write strobe.
- Sits between instruction memory, data memory and the register file/ALU. Replaces the single-cycle flow so that data memory may take variable latency.

Parameters:
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
- INSTR_W, 9, instruction width; opcode is instr[8:6], rd/rs is instr[5:3], imm/rs2 is instr[2:0].
- PROG_LEN, 256, PC value at which execution ends (done).
- MEM_TIMEOUT, 15, maximum cycles to wait for dmem_ack before an error is flagged.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins execution at PC=0 when in IDLE or DONE
- imem_addr  out  PC_W  instruction fetch address, equal to pc
- imem_rdata  in  INSTR_W  instruction word, valid the cycle after imem_addr
- zero_flag  in  1  1 when the register selected by ir[5:3] equals 0 (for bnez)
- dmem_req  out  1  data-memory request, held until ack
- dmem_we  out  1  1 = store (sw), 0 = load (lw); valid while dmem_req
- dmem_ack  in  1  single-cycle completion pulse from data memory
- ir  out  INSTR_W  latched instruction
- alu_op  out  3  opcode presented to the ALU, valid in EXEC
- two_reg  out  1  high in EXEC for xor and and
- reg_we  out  1  one-cycle register-file write strobe
- pc  out  PC_W  current program counter
- busy  out  1  high in any state other than IDLE or DONE
- done  out  1  high in DONE
- mem_err  out  1  sticky; set on dmem timeout, cleared by start
- instr_count  out  16  instructions retired, saturating at 16'hFFFF

Behaviour:
- Reset, asynchronous with rst_n=0:
  - State goes to IDLE.
  - pc, ir, instr_count, mem_err and all strobes go to 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
- IDLE/DONE: on start, pc<=0, mem_err<=0, instr_count<=0, then go to FETCH. Otherwise hold.
- FETCH (1 cycle): imem_addr=pc; ir<=imem_rdata at the cycle end; go to DECODE.
- DECODE (1 cycle): opcode is decoded into mem/jump/two_reg classes; go to EXEC.
- EXEC (1 cycle): alu_op=ir[8:6]; two_reg is set for opcodes 011 and 111.
  - lw (000) and sw (001): go to MEM.
  - bnez (010): retire the instruction.
    - If zero_flag=0 (taken) and the sign-extended ir[2:0] offset is 0, go to DONE (self-loop halt).
    - If taken with a nonzero offset, pc<=pc+sext(ir[2:0]) modulo 2^PC_W, then go to FETCH.
    - If not taken, pc<=pc+1 and go to the next-PC check.
  - xor, inc, shl, shr, and (011–111): go to WB.
- MEM: dmem_req=1 and dmem_we=(opcode==001), both stable until ack.
  - On dmem_ack, go to WB for lw. For sw, retire with pc<=pc+1 and go to the next-PC check.
  - The wait counter starts at 0 on MEM entry. If it reaches MEM_TIMEOUT with no ack, set mem_err, drop dmem_req and go to DONE.
  - An ack arriving in the same cycle as the timeout wins; no error is flagged.
- WB (1 cycle): reg_we=1; pc<=pc+1; retire; go to the next-PC check.
- Next-PC check: if the new pc equals PROG_LEN (compared in PC_W+1 bits), go to DONE; otherwise go to FETCH.
- Retire: instr_count increments by 1 per retired instruction. A timed-out instruction does not retire.
- start while busy is ignored.
- dmem_ack outside MEM is ignored.
- rst_n asserted mid-MEM drops dmem_req immediately, asynchronously.
- Latency per opcode:
  - ALU ops: 4 cycles.
  - bnez: 3 cycles.
  - sw: 3+N cycles, where N is the number of cycles spent in MEM.
  - lw: 4+N cycles.

Decomposition:
- Shared package core_pkg holds:
  - the opcode enum (OP_LW=000 … OP_AND=111);
  - the state enum seq_state_t;
  - the field-slice constants for opcode, rd and imm.
- One natural sub-module, seq_mem_timer: a loadable down-counter with a timeout flag, used in MEM.
- Opcode class flags come from the team's existing control decoder, instantiated on ir[8:6].

Test Plan:
- Reset mid-run:
  - Stimulus: rst_n low during MEM with dmem_req=1.
  - Response: dmem_req=0 in the same cycle; pc=0, state IDLE, busy=0.
- ALU op:
  - Stimulus: start with instr 100_001_011 (inc) at pc 0.
  - Response: reg_we high exactly 4 cycles after FETCH entry; pc=1; instr_count=1.
- Load with latency:
  - Stimulus: lw with dmem_ack returned 3 cycles after dmem_req rises.
  - Response: dmem_we=0 held through the wait; WB follows; total 7 cycles; pc advances by 1.
- Branches at pc=5:
  - bnez with offset 3'b110 and zero_flag=0: pc=3.
  - Same instruction with zero_flag=1: pc=6.
  - Offset 0 with zero_flag=0: done=1, instr_count increments.
- Memory timeout:
  - Stimulus: sw with no ack.
  - Response: mem_err=1 after 15 MEM cycles; state DONE; instr_count unchanged.
  - Next start: mem_err clears.
  - Ack exactly on cycle 15: no error.
- End of program:
  - Stimulus: PROG_LEN=4 with four ALU ops.
  - Response: done=1 after 16 cycles; instr_count=4; start while busy is ignored.
